// File: rtl/cp0_exc.sv
// Coprocessor 0 for the 5-stage MIPS core.
// Handles precise exceptions and level-sensitive interrupts reported from the MEM stage, the
// Count/Compare timer, and mfc0/mtc0/eret access to the CP0 register file.
module cp0_exc #(
  parameter int unsigned NHW      = 6,
  parameter bit          TIMER_EN = 1'b1,
  parameter logic [31:0] PRID     = 32'h0000_1800
) (
  input  logic           clk,
  input  logic           reset,
  // mfc0 / mtc0 access
  input  logic [4:0]     sel,
  input  logic [31:0]    wdata,
  input  logic           we,
  output logic [31:0]    rdata,
  // MEM-stage exception reporting
  input  logic [31:0]    pc,
  input  logic           bd,
  input  logic           exc_req,
  input  logic [4:0]     exc_code,
  input  logic [31:0]    bad_vaddr,
  input  logic [NHW-1:0] hw_int,
  input  logic           eret,
  // To hazard unit / fetch redirect
  output logic           trap,
  output logic [31:0]    epc,
  output logic           exl
);

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  // Architectural state
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  // Timer state (tied to zero when the timer is not built)
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;

  // Write strobes for the non-timer registers
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  // Interrupt pending bits IP[15:10] and the qualified interrupt request
  logic [5:0] ip_hw;
  logic [5:0] ip;
  logic       int_pend;

  assign wr_status = we && (sel == RegStatus);
  assign wr_cause  = we && (sel == RegCause);
  assign wr_epc    = we && (sel == RegEpc);

  // Zero-extend the device lines into IP[15:10]; the timer shares the top line.
  always_comb begin
    ip_hw = '0;
    for (int i = 0; i < NHW; i++) begin
      ip_hw[i] = hw_int[i];
    end
    ip    = ip_hw;
    ip[5] = ip_hw[5] | ti_q;
  end

  // Trap decision: EXL masks both exceptions and interrupts, IE only masks interrupts.
  always_comb begin
    int_pend = (|(ip & im_q)) && ie_q && !exl_q;
    trap     = (exc_req || int_pend) && !exl_q;
  end

  // Next-state for Status/Cause/EPC/BadVAddr. Later assignments take priority:
  // eret < mtc0 < trap for the fields a trap owns.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (eret && exl_q) begin
      exl_d = 1'b0;
    end

    if (wr_status) begin
      im_d  = wdata[15:10];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end

    // Only ExcCode is software-writable in Cause.
    if (wr_cause) begin
      exc_code_d = wdata[6:2];
    end

    if (wr_epc) begin
      epc_d = wdata;
    end

    if (trap) begin
      exl_d      = 1'b1;
      epc_d      = bd ? (pc - 32'd4) : pc;
      bd_d       = bd;
      // Exception wins over a simultaneous interrupt; interrupts report code 0.
      exc_code_d = exc_req ? exc_code : 5'd0;
      if (exc_req && ((exc_code == ExcAdEL) || (exc_code == ExcAdES))) begin
        badvaddr_d = bad_vaddr;
      end
    end
  end

  // Status/Cause/EPC/BadVAddr registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= 6'h3f;
      exl_q      <= 1'b0;
      ie_q       <= 1'b1;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  if (TIMER_EN) begin : g_timer
    logic        wr_count;
    logic        wr_compare;
    logic [31:0] count_d;
    logic [31:0] compare_d;
    logic        ti_d;

    assign wr_count   = we && (sel == RegCount);
    assign wr_compare = we && (sel == RegCompare);

    // Count free-runs; the match uses the pre-increment value, a Compare write acks TI.
    always_comb begin
      count_d   = wr_count ? wdata : (count_q + 32'd1);
      compare_d = wr_compare ? wdata : compare_q;
      ti_d      = ti_q;
      if (count_q == compare_q) begin
        ti_d = 1'b1;
      end
      if (wr_compare) begin
        ti_d = 1'b0;
      end
    end

    // Timer registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q   <= 32'd0;
        compare_q <= 32'd0;
        ti_q      <= 1'b0;
      end else begin
        count_q   <= count_d;
        compare_q <= compare_d;
        ti_q      <= ti_d;
      end
    end
  end else begin : g_no_timer
    assign count_q   = 32'd0;
    assign compare_q = 32'd0;
    assign ti_q      = 1'b0;
  end

  // mfc0 read mux, purely combinational from sel
  always_comb begin
    rdata = 32'd0;
    case (sel)
      RegBadVAddr: rdata = badvaddr_q;
      RegCount:    rdata = count_q;
      RegCompare:  rdata = compare_q;
      RegStatus:   rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
      RegCause:    rdata = {bd_q, ti_q, 14'b0, ip, 3'b0, exc_code_q, 2'b0};
      RegEpc:      rdata = epc_q;
      RegPrid:     rdata = PRID;
      default:     rdata = 32'd0;
    endcase
  end

  assign epc = epc_q;
  assign exl = exl_q;

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: expected values are queued as stimulus is applied and
// compared in order as the DUT produces them.
module tb_cp0_exc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sel;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic [5:0]  hw_int;
  logic        eret;
  logic        trap;
  logic [31:0] epc;
  logic        exl;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cp0_exc #(
    .NHW      (6),
    .TIMER_EN (1'b1),
    .PRID     (32'h0000_1800)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .pc        (pc),
    .bd        (bd),
    .exc_req   (exc_req),
    .exc_code  (exc_code),
    .bad_vaddr (bad_vaddr),
    .hw_int    (hw_int),
    .eret      (eret),
    .trap      (trap),
    .epc       (epc),
    .exl       (exl)
  );

  always #10 clk = ~clk;

  task automatic want(input string n, input logic [31:0] v);
    sb.push_back('{name: n, val: v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    sel   = s;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] s, output logic [31:0] v);
    sel = s;
    #1;
    v = rdata;
  endtask

  // Release reset with a Compare write on the first edge so TI does not fire at Count == 0.
  task automatic release_reset();
    sel   = 5'd11;
    wdata = 32'hffff_ffff;
    we    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    mtc0(5'd12, 32'h0000_fc03);
    mtc0(5'd9, 32'd500);
    want("pre_count", 32'd500);
    rd(5'd9, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("pre_exl", 32'd1);
    o = {31'b0, exl}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    reset = 1'b1;
    #1;
    want("rst_exl", 32'd0);
    want("rst_trap", 32'd0);
    want("rst_status", 32'h0000_fc01);
    want("rst_count", 32'd0);
    want("rst_epc", 32'd0);
    o = {31'b0, exl}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd12, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd9, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    release_reset();
  endtask

  task automatic test_interrupt();
    exp_t e;
    logic [31:0] o;
    pc     = 32'h0000_1000;
    bd     = 1'b0;
    hw_int = 6'b000100;
    want("int_trap", 32'd1);
    #1;
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("int_exl", 32'd1);
    want("int_epc", 32'h0000_1000);
    want("int_trap_masked", 32'd0);
    want("int_cause", 32'h0000_1000);
    tick();
    o = {31'b0, exl}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd13, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    hw_int = 6'b0;
    eret   = 1'b1;
    want("int_eret_exl", 32'd0);
    tick();
    eret = 1'b0;
    o = {31'b0, exl}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
  endtask

  task automatic test_exception();
    exp_t e;
    logic [31:0] o;
    pc        = 32'h0000_3008;
    bd        = 1'b1;
    exc_req   = 1'b1;
    exc_code  = 5'd5;
    bad_vaddr = 32'h0000_1003;
    hw_int    = 6'b000001;
    want("exc_trap", 32'd1);
    #1;
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("exc_epc", 32'h0000_3004);
    want("exc_cause", 32'h8000_0014);
    want("exc_badvaddr", 32'h0000_1003);
    tick();
    exc_req = 1'b0;
    hw_int  = 6'b0;
    bd      = 1'b0;
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd13, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd8, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    // A second exception while EXL is set must be ignored entirely.
    exc_req   = 1'b1;
    exc_code  = 5'd4;
    bad_vaddr = 32'h0000_dead;
    pc        = 32'h0000_5000;
    want("nested_trap", 32'd0);
    #1;
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("nested_badvaddr", 32'h0000_1003);
    want("nested_epc", 32'h0000_3004);
    tick();
    exc_req = 1'b0;
    rd(5'd8, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    // Syscall must not disturb BadVAddr.
    exc_req   = 1'b1;
    exc_code  = 5'd8;
    bad_vaddr = 32'h0000_beef;
    pc        = 32'h0000_7000;
    want("sys_badvaddr", 32'h0000_1003);
    want("sys_cause", 32'h0000_0020);
    want("sys_epc", 32'h0000_7000);
    tick();
    exc_req = 1'b0;
    rd(5'd8, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd13, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_timer();
    exp_t e;
    logic [31:0] o;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'hffff_ffff);
    want("cnt_write", 32'hffff_ffff);
    rd(5'd9, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("cnt_wrap", 32'd0);
    tick();
    rd(5'd9, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    mtc0(5'd9, 32'd10);
    want("cnt_ten", 32'd10);
    rd(5'd9, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    // Count is 11 after this edge; it equals 20 nine edges later and TI sets one edge after.
    mtc0(5'd11, 32'd20);
    want("ti_early_trap", 32'd0);
    want("ti_early_cause", 32'd0);
    repeat (9) tick();
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd13, o); o = o & 32'hc000_fc00; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("ti_trap", 32'd1);
    want("ti_cause", 32'h4000_8000);
    want("ti_count", 32'd21);
    tick();
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd13, o); o = o & 32'hc000_fc00; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    rd(5'd9, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    pc = 32'h0000_9000;
    want("ti_taken_epc", 32'h0000_9000);
    tick();
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    mtc0(5'd11, 32'hffff_ffff);
    want("ti_ack_cause", 32'd0);
    rd(5'd13, o); o = o & 32'hc000_fc00; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_eret_pending();
    exp_t e;
    logic [31:0] o;
    pc     = 32'h0000_a000;
    hw_int = 6'b000010;
    want("ep_enter_exl", 32'd1);
    tick();
    o = {31'b0, exl}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    eret = 1'b1;
    want("ep_eret_trap", 32'd0);
    #1;
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("ep_exl_clr", 32'd0);
    want("ep_retrap", 32'd1);
    tick();
    eret = 1'b0;
    o = {31'b0, exl}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = {31'b0, trap}; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    tick();
    hw_int = 6'b0;
    eret   = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_status_trap();
    exp_t e;
    logic [31:0] o;
    pc     = 32'h0000_6000;
    bd     = 1'b0;
    hw_int = 6'b001000;
    want("st_status", 32'h0000_0402);
    want("st_epc", 32'h0000_6000);
    mtc0(5'd12, 32'h0000_0400);
    hw_int = 6'b0;
    rd(5'd12, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    // eret and an mtc0 Status together: the written EXL wins.
    eret = 1'b1;
    want("st_eret_we", 32'h0000_fc03);
    mtc0(5'd12, 32'h0000_fc03);
    eret = 1'b0;
    rd(5'd12, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    want("st_sw_clear", 32'h0000_fc01);
    mtc0(5'd12, 32'h0000_fc01);
    rd(5'd12, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
  endtask

  task automatic test_regs();
    exp_t e;
    logic [31:0] o;
    mtc0(5'd15, 32'h0);
    want("prid", 32'h0000_1800);
    rd(5'd15, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    mtc0(5'd3, 32'h1234_5678);
    want("unlisted", 32'd0);
    rd(5'd3, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    mtc0(5'd8, 32'h0);
    want("badvaddr_ro", 32'h0000_1003);
    rd(5'd8, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    mtc0(5'd13, 32'hffff_ffff);
    want("cause_wr", 32'h0000_007c);
    rd(5'd13, o); e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
    mtc0(5'd14, 32'h0000_1234);
    want("epc_wr", 32'h0000_1234);
    o = epc; e = sb.pop_front(); total++;
    if (o !== e.val) begin bad++; $display("FAIL %s: got=%h want=%h", e.name, o, e.val); end
  endtask

  initial begin
    reset     = 1'b1;
    sel       = 5'd0;
    wdata     = 32'd0;
    we        = 1'b0;
    pc        = 32'd0;
    bd        = 1'b0;
    exc_req   = 1'b0;
    exc_code  = 5'd0;
    bad_vaddr = 32'd0;
    hw_int    = 6'b0;
    eret      = 1'b0;
    #25;
    release_reset();
    test_reset();
    test_interrupt();
    test_exception();
    test_timer();
    test_eret_pending();
    test_status_trap();
    test_regs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
